// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants and FSM state type for the LFSR stream generator
package lfsr_pkg;

  localparam int unsigned LFSR_MODE_GALOIS = 0;
  localparam int unsigned LFSR_MODE_FIB    = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } lfsr_fsm_e;

  // Defaults describe the maximal-length 8-bit generator being replaced.
  localparam logic [7:0] LFSR_GAL_TAPS_8 = 8'h1D;
  localparam logic [7:0] LFSR_FIB_TAPS_8 = 8'hB8;
  localparam logic [7:0] LFSR_SEED_8     = 8'h01;

endpackage

// File: rtl/lfsr_next_state.sv
// rtl/lfsr_next_state.sv - combinational LFSR next-state function (Galois or Fibonacci)
module lfsr_next_state
  import lfsr_pkg::*;
#(
  parameter int unsigned          WIDTH    = 8,
  parameter int unsigned          MODE     = LFSR_MODE_GALOIS,
  parameter logic [WIDTH-1:0]     GAL_TAPS = WIDTH'(LFSR_GAL_TAPS_8),
  parameter logic [WIDTH-1:0]     FIB_TAPS = WIDTH'(LFSR_FIB_TAPS_8)
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] next_o
);

  generate
    if (MODE == LFSR_MODE_GALOIS) begin : g_galois
      assign next_o = {state_i[WIDTH-2:0], 1'b0} ^ (state_i[WIDTH-1] ? GAL_TAPS : '0);
    end else begin : g_fib
      logic fb;
      assign fb     = ^(state_i & FIB_TAPS);
      assign next_o = {state_i[WIDTH-2:0], fb};
    end
  endgenerate

endmodule

// File: rtl/lfsr_stream_gen.sv
// rtl/lfsr_stream_gen.sv - LFSR word generator on a valid/ready stream with run FSM and seed load
// Optional step counter output enabled by LFSR_STEP_CNT_EN.
module lfsr_stream_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH        = 8,
  parameter int unsigned      MODE         = LFSR_MODE_GALOIS,
  parameter logic [WIDTH-1:0] GAL_TAPS     = WIDTH'(LFSR_GAL_TAPS_8),
  parameter logic [WIDTH-1:0] FIB_TAPS     = WIDTH'(LFSR_FIB_TAPS_8),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(LFSR_SEED_8)
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_seed_load,
  input  logic [WIDTH-1:0] i_seed,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_wrap,
  output logic             o_seed_err
`ifdef LFSR_STEP_CNT_EN
  ,
  output logic [WIDTH-1:0] o_step_cnt
`endif
);

  lfsr_fsm_e        fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] next_w;
  logic [WIDTH-1:0] load_val;
  logic             wrap_q, wrap_d;
  logic             seed_err_q, seed_err_d;
  logic             seed_zero;
  logic             step;

  lfsr_next_state #(
    .WIDTH    (WIDTH),
    .MODE     (MODE),
    .GAL_TAPS (GAL_TAPS),
    .FIB_TAPS (FIB_TAPS)
  ) u_next (
    .state_i (state_q),
    .next_o  (next_w)
  );

  assign step      = (fsm_q == ST_RUN) && i_ready;
  assign seed_zero = (i_seed == '0);
  assign load_val  = seed_zero ? DEFAULT_SEED : i_seed;

  // Stop has priority over start so a simultaneous request leaves the generator idle.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE: if (i_start && !i_stop) fsm_d = ST_RUN;
      ST_RUN:  if (i_stop)             fsm_d = ST_IDLE;
      default:                         fsm_d = ST_IDLE;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    seed_d     = seed_q;
    wrap_d     = 1'b0;
    seed_err_d = 1'b0;
    if (i_seed_load) begin
      state_d    = load_val;
      seed_d     = load_val;
      seed_err_d = seed_zero;
    end else if (step) begin
      state_d = next_w;
      wrap_d  = (next_w == seed_q);
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      fsm_q      <= ST_IDLE;
      state_q    <= DEFAULT_SEED;
      seed_q     <= DEFAULT_SEED;
      wrap_q     <= 1'b0;
      seed_err_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      seed_q     <= seed_d;
      wrap_q     <= wrap_d;
      seed_err_q <= seed_err_d;
    end
  end

  assign o_data     = state_q;
  assign o_valid    = (fsm_q == ST_RUN);
  assign o_wrap     = wrap_q;
  assign o_seed_err = seed_err_q;

`ifdef LFSR_STEP_CNT_EN
  logic [WIDTH-1:0] step_cnt_q, step_cnt_d;

  always_comb begin
    step_cnt_d = step_cnt_q;
    if (i_seed_load) begin
      step_cnt_d = '0;
    end else if (step) begin
      step_cnt_d = (next_w == seed_q) ? '0 : step_cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) step_cnt_q <= '0;
    else       step_cnt_q <= step_cnt_d;
  end

  assign o_step_cnt = step_cnt_q;
`else
  // Step counter not built.
`endif

endmodule
